// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-controller bus: hazard information from the pipeline registers and
// the stall/flush/redirect controls plus statistics going back.
interface pipeline_hazard_controller_if #(
    parameter int CNT_W = 16
);
    logic             ID_EX_MemRead;
    logic [4:0]       ID_EX_WriteRegister;
    logic [4:0]       IF_ID_Rs;
    logic [4:0]       IF_ID_Rt;
    logic             EX_MEM_BranchEQ;
    logic             EX_MEM_BranchNE;
    logic             EX_MEM_Jump;
    logic             EX_MEM_Zero;
    logic             EX_MEM_MemRead;
    logic             EX_MEM_MemWrite;
    logic             mem_ready;
    logic             clear_stats;

    logic             PC_Write;
    logic             IF_ID_Write;
    logic             ID_EX_Write;
    logic             EX_MEM_Write;
    logic             IF_ID_Flush;
    logic             ID_EX_Flush;
    logic             EX_MEM_Flush;
    logic             PC_Redirect;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;
    logic             mem_timeout_err;

    // Pipeline side: supplies hazard information, consumes controls
    modport master (
        output ID_EX_MemRead, ID_EX_WriteRegister, IF_ID_Rs, IF_ID_Rt,
               EX_MEM_BranchEQ, EX_MEM_BranchNE, EX_MEM_Jump, EX_MEM_Zero,
               EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready, clear_stats,
        input  PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PC_Redirect,
               stall_count, flush_count, mem_timeout_err
    );

    // Controller side
    modport slave (
        input  ID_EX_MemRead, ID_EX_WriteRegister, IF_ID_Rs, IF_ID_Rt,
               EX_MEM_BranchEQ, EX_MEM_BranchNE, EX_MEM_Jump, EX_MEM_Zero,
               EX_MEM_MemRead, EX_MEM_MemWrite, mem_ready, clear_stats,
        output PC_Write, IF_ID_Write, ID_EX_Write, EX_MEM_Write,
               IF_ID_Flush, ID_EX_Flush, EX_MEM_Flush, PC_Redirect,
               stall_count, flush_count, mem_timeout_err
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Pipeline hazard controller: resolves memory waits, taken branches/jumps and
// load-use hazards (priority in that order) into stage write enables,
// flushes and a PC redirect, and keeps saturating stall/flush statistics
// plus a sticky memory-timeout flag.
module pipeline_hazard_controller #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 255
) (
    input  logic                         clk,
    input  logic                         reset,
    pipeline_hazard_controller_if.slave  bus
);

    // Wait counter only ever needs to reach TIMEOUT before the FSM leaves MEM_WAIT
    localparam int                WAIT_W     = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);
    localparam logic [WAIT_W-1:0] WAIT_ONE   = WAIT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX    = '1;

    typedef enum logic [1:0] {
        RUN,
        MEM_WAIT,
        FLUSH,
        LOAD_STALL
    } state_t;

    state_t            state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_count;
    logic [WAIT_W-1:0] wait_next;
    logic [CNT_W-1:0]  stall_count;
    logic [CNT_W-1:0]  flush_count;
    logic              timeout_err;

    logic taken;
    logic load_use;
    logic mem_busy;
    logic timeout_hit;

    logic pc_write;
    logic if_id_write;
    logic id_ex_write;
    logic ex_mem_write;
    logic if_id_flush;
    logic id_ex_flush;
    logic ex_mem_flush;
    logic pc_redirect;

    assign taken = (bus.EX_MEM_BranchEQ & bus.EX_MEM_Zero)
                 | (bus.EX_MEM_BranchNE & ~bus.EX_MEM_Zero)
                 | bus.EX_MEM_Jump;

    // Register 0 is hard-wired, so a load into it can never create a hazard
    assign load_use = bus.ID_EX_MemRead
                    & (bus.ID_EX_WriteRegister != 5'd0)
                    & ((bus.ID_EX_WriteRegister == bus.IF_ID_Rs)
                     | (bus.ID_EX_WriteRegister == bus.IF_ID_Rt));

    assign mem_busy = (bus.EX_MEM_MemRead | bus.EX_MEM_MemWrite) & ~bus.mem_ready;

    // Next state, wait-counter update and combinational stage controls
    always_comb begin
        next_state   = state;
        wait_next    = wait_count;
        timeout_hit  = 1'b0;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_write  = 1'b1;
        ex_mem_write = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;
        pc_redirect  = 1'b0;

        case (state)
            RUN: begin
                if (mem_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    wait_next    = WAIT_ONE;
                    next_state   = MEM_WAIT;
                end else if (taken) begin
                    pc_redirect  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    next_state   = FLUSH;
                end else if (load_use) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_flush  = 1'b1;
                    next_state   = LOAD_STALL;
                end
            end

            MEM_WAIT: begin
                if (bus.mem_ready) begin
                    wait_next  = '0;
                    next_state = RUN;
                end else if (wait_count >= WAIT_LIMIT) begin
                    timeout_hit = 1'b1;
                    wait_next   = '0;
                    next_state  = RUN;
                end else begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    wait_next    = wait_count + WAIT_ONE;
                end
            end

            FLUSH: begin
                if (mem_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    wait_next    = WAIT_ONE;
                    next_state   = MEM_WAIT;
                end else begin
                    next_state = RUN;
                end
            end

            LOAD_STALL: begin
                if (mem_busy) begin
                    pc_write     = 1'b0;
                    if_id_write  = 1'b0;
                    id_ex_write  = 1'b0;
                    ex_mem_write = 1'b0;
                    wait_next    = WAIT_ONE;
                    next_state   = MEM_WAIT;
                end else if (taken) begin
                    pc_redirect  = 1'b1;
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    next_state   = FLUSH;
                end else begin
                    next_state = RUN;
                end
            end

            default: begin
                next_state = RUN;
                wait_next  = '0;
            end
        endcase

        // Reset freezes every stage and drops any redirect immediately
        if (reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_write = 1'b0;
            if_id_flush  = 1'b0;
            id_ex_flush  = 1'b0;
            ex_mem_flush = 1'b0;
            pc_redirect  = 1'b0;
            timeout_hit  = 1'b0;
        end
    end

    // State and wait-counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= RUN;
            wait_count <= '0;
        end else begin
            state      <= next_state;
            wait_count <= wait_next;
        end
    end

    // Statistics and sticky timeout flag; clear_stats wins over any update
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            flush_count <= '0;
            timeout_err <= 1'b0;
        end else if (bus.clear_stats) begin
            stall_count <= '0;
            flush_count <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (!pc_write && (stall_count != CNT_MAX)) begin
                stall_count <= stall_count + 1'b1;
            end
            if (pc_redirect && (flush_count != CNT_MAX)) begin
                flush_count <= flush_count + 1'b1;
            end
            if (timeout_hit) begin
                timeout_err <= 1'b1;
            end
        end
    end

    assign bus.PC_Write        = pc_write;
    assign bus.IF_ID_Write     = if_id_write;
    assign bus.ID_EX_Write     = id_ex_write;
    assign bus.EX_MEM_Write    = ex_mem_write;
    assign bus.IF_ID_Flush     = if_id_flush;
    assign bus.ID_EX_Flush     = id_ex_flush;
    assign bus.EX_MEM_Flush    = ex_mem_flush;
    assign bus.PC_Redirect     = pc_redirect;
    assign bus.stall_count     = stall_count;
    assign bus.flush_count     = flush_count;
    assign bus.mem_timeout_err = timeout_err;

endmodule
